// File: rtl/clock_route_pkg.sv
// clock_route_pkg: shared FSM state type and counter sizing for the clock route mux
package clock_route_pkg;
  typedef enum logic [1:0] {IDLE, ON, DRAIN, SETTLE} route_state_e;
  function automatic int cnt_width(input int dead_cycles);
    return (dead_cycles < 1) ? 1 : $clog2(dead_cycles + 1);
  endfunction
endpackage

// File: rtl/clock_cell_or.sv
// clock_cell_or: two-input OR cell for merging gated clocks
module clock_cell_or (
  input  logic a_i,
  input  logic b_i,
  output logic y_o
);
  assign y_o = a_i | b_i;
endmodule

// File: rtl/clock_route_path_gate.sv
// clock_route_path_gate: glitch-free clock gate, enable captured while the path clock is low
module clock_route_path_gate (
  input  logic clk_i,
  input  logic en_i,
  input  logic test_en_i,
  output logic clk_o
);
  logic en_q;
  always_latch begin
    if (!clk_i) en_q <= en_i | test_en_i;
  end
  assign clk_o = clk_i & en_q;
endmodule

// File: rtl/clock_route_path_mux_n.sv
// clock_route_path_mux_n: break-before-make N-way clock path selector with gated outputs
module clock_route_path_mux_n
  import clock_route_pkg::*;
#(
  parameter  int NUM_PATHS   = 4,
  parameter  int DEAD_CYCLES = 4,
  localparam int SEL_W       = $clog2(NUM_PATHS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_PATHS-1:0] clock_route_path_in,
  output logic                 clock_route_path_out,
  input  logic                 sel_req_valid,
  output logic                 sel_req_ready,
  input  logic [SEL_W-1:0]     sel_req_path,
  input  logic                 sel_req_off,
  input  logic                 async_test_en,
  output logic [NUM_PATHS-1:0] path_enable,
  output logic [SEL_W-1:0]     active_path,
  output logic                 path_active,
  output logic                 switch_done,
  output logic                 sel_err
);
  localparam int CW = cnt_width(DEAD_CYCLES);
  localparam int P2 = 1 << SEL_W;
  localparam logic [P2-1:0] PATH_MASK = P2'((64'd1 << NUM_PATHS) - 64'd1);

  route_state_e         state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [SEL_W-1:0]     tgt_q, tgt_d, act_q, act_d;
  logic                 off_q, off_d, done_q, done_d, err_q, err_d;
  logic [NUM_PATHS-1:0] pen_q, pen_d, req_oh, tgt_oh, gated;
  logic                 accept, path_ok;

  assign sel_req_ready = (state_q == IDLE) || (state_q == ON);
  assign accept        = sel_req_valid && sel_req_ready;
  assign path_ok       = PATH_MASK[sel_req_path];
  assign req_oh        = NUM_PATHS'(1) << sel_req_path;
  assign tgt_oh        = NUM_PATHS'(1) << tgt_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    off_d   = off_q;
    pen_d   = pen_q;
    act_d   = act_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE, ON: begin
        if (accept) begin
          if (!sel_req_off && !path_ok) err_d = 1'b1;
          else if (sel_req_off ? (state_q == IDLE) : (state_q == ON && sel_req_path == tgt_q)) done_d = 1'b1;
          else if (state_q == IDLE) begin
            tgt_d   = sel_req_path;
            off_d   = 1'b0;
            pen_d   = req_oh;
            cnt_d   = CW'(DEAD_CYCLES);
            state_d = SETTLE;
          end else begin
            tgt_d   = sel_req_off ? tgt_q : sel_req_path;
            off_d   = sel_req_off;
            pen_d   = '0;
            cnt_d   = CW'(DEAD_CYCLES);
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          if (off_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            pen_d   = tgt_oh;
            cnt_d   = CW'(DEAD_CYCLES);
            state_d = SETTLE;
          end
        end
      end
      SETTLE: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          act_d   = tgt_q;
          state_d = ON;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Async clear drops every enable the instant reset asserts, even mid-switch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tgt_q   <= '0;
      off_q   <= 1'b0;
      pen_q   <= '0;
      act_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
      off_q   <= off_d;
      pen_q   <= pen_d;
      act_q   <= act_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign path_enable = pen_q;
  assign active_path = act_q;
  assign path_active = (state_q == ON);
  assign switch_done = done_q;
  assign sel_err     = err_q;

  for (genvar i = 0; i < NUM_PATHS; i++) begin : g_gate
    clock_route_path_gate u_gate (
      .clk_i    (clock_route_path_in[i]),
      .en_i     (pen_q[i]),
      .test_en_i(async_test_en),
      .clk_o    (gated[i])
    );
  end

  // Balanced OR tree; each level is its own vector so no signal feeds back into itself
  logic [P2-1:0] leaf;
  assign leaf = P2'(gated);
  for (genvar l = 0; l < SEL_W; l++) begin : g_lvl
    logic [(P2 >> (l + 1))-1:0] y;
    for (genvar k = 0; k < (P2 >> (l + 1)); k++) begin : g_cell
      logic a, b;
      if (l == 0) begin : g_leaf
        assign a = leaf[2*k];
        assign b = leaf[2*k+1];
      end else begin : g_node
        assign a = g_lvl[l-1].y[2*k];
        assign b = g_lvl[l-1].y[2*k+1];
      end
      clock_cell_or u_or (.a_i(a), .b_i(b), .y_o(y[k]));
    end
  end
  assign clock_route_path_out = g_lvl[SEL_W-1].y[0];
endmodule

// File: tb/tb_clock_route_path_mux_n.sv
// tb_clock_route_path_mux_n: directed self-checking bench for the clock route path mux
module tb_clock_route_path_mux_n;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] path_in = '0;
  logic       valid = 1'b0;
  logic [1:0] path = '0;
  logic       off = 1'b0;
  logic       test_en = 1'b0;
  logic       out, ready, pact, done, err;
  logic [3:0] pen;
  logic [1:0] act;
  logic [4:0] in5 = '0;
  logic       v5 = 1'b0;
  logic [2:0] p5 = '0;
  logic       o5, ready5, pact5, done5, err5;
  logic [4:0] pen5;
  logic [2:0] act5;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  clock_route_path_mux_n u_dut (
    .clk(clk), .rst_n(rst_n), .clock_route_path_in(path_in), .clock_route_path_out(out),
    .sel_req_valid(valid), .sel_req_ready(ready), .sel_req_path(path), .sel_req_off(off),
    .async_test_en(test_en), .path_enable(pen), .active_path(act), .path_active(pact),
    .switch_done(done), .sel_err(err)
  );

  clock_route_path_mux_n #(.NUM_PATHS(5), .DEAD_CYCLES(2)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .clock_route_path_in(in5), .clock_route_path_out(o5),
    .sel_req_valid(v5), .sel_req_ready(ready5), .sel_req_path(p5), .sel_req_off(1'b0),
    .async_test_en(1'b0), .path_enable(pen5), .active_path(act5), .path_active(pact5),
    .switch_done(done5), .sel_err(err5)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    chk("onehot", 32'($countones(pen) <= 1 && $countones(pen5) <= 1), 1);
  endtask

  task automatic out_chk(input string tag, input logic [3:0] pat, input logic [31:0] exp);
    path_in = '0;
    #1 path_in = pat;
    #1 chk(tag, 32'(out), exp);
    path_in = '0;
  endtask

  task automatic req(input logic [1:0] p, input logic o);
    valid = 1'b1;
    path = p;
    off = o;
    tick();
    valid = 1'b0;
    off = 1'b0;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1;
    chk("rst_pen", 32'(pen), 0);
    chk("rst_ready", 32'(ready), 1);
    chk("rst_act", 32'(act), 0);
    chk("rst_pact", 32'(pact), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    // IDLE -> path 2, with a held request for path 1 that must be ignored during SETTLE
    valid = 1'b1;
    path = 2'd2;
    tick();
    path = 2'd1;
    chk("on2_pen", 32'(pen), 4'b0100);
    chk("on2_ready", 32'(ready), 0);
    for (int k = 2; k <= 4; k++) begin
      tick();
      chk("settle_done", 32'(done), 0);
      chk("settle_ready", 32'(ready), 0);
      chk("settle_pen", 32'(pen), 4'b0100);
    end
    tick();
    chk("on2_done", 32'(done), 1);
    chk("on2_act", 32'(act), 2);
    chk("on2_pact", 32'(pact), 1);
    chk("on2_ready1", 32'(ready), 1);
    valid = 1'b0;
    out_chk("out_on2", 4'b0100, 1);
    tick();
    chk("on2_done_clr", 32'(done), 0);
    chk("on2_noqueue", 32'(pen), 4'b0100);
    out_chk("out_other", 4'b1011, 0);
    // ON path 2 -> path 0: break for 4 cycles, then settle 4 cycles
    valid = 1'b1;
    path = 2'd0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      valid = 1'b0;
      chk("sw_pen", 32'(pen), (k <= 4) ? 0 : 1);
      chk("sw_done", 32'(done), 32'(k == 9));
      chk("sw_act", 32'(act), (k == 9) ? 0 : 2);
      if (k == 2) out_chk("out_drain", 4'b1111, 0);
    end
    tick();
    chk("sw_done_clr", 32'(done), 0);
    // same path while ON
    req(2'd0, 1'b0);
    chk("same_done", 32'(done), 1);
    chk("same_pen", 32'(pen), 4'b0001);
    chk("same_pact", 32'(pact), 1);
    tick();
    chk("same_done_clr", 32'(done), 0);
    // off from ON: drain then IDLE
    valid = 1'b1;
    off = 1'b1;
    path = 2'd3;
    for (int k = 1; k <= 5; k++) begin
      tick();
      valid = 1'b0;
      off = 1'b0;
      chk("off_pen", 32'(pen), 0);
      chk("off_done", 32'(done), 32'(k == 5));
      chk("off_ready", 32'(ready), 32'(k == 5));
    end
    chk("off_pact", 32'(pact), 0);
    // off while IDLE
    req(2'd1, 1'b1);
    chk("idle_off_done", 32'(done), 1);
    chk("idle_off_pen", 32'(pen), 0);
    chk("idle_off_ready", 32'(ready), 1);
    tick();
    chk("idle_off_clr", 32'(done), 0);
    // test override with all enables low
    test_en = 1'b1;
    out_chk("tst_hi", 4'b0010, 1);
    tick();
    chk("tst_pen", 32'(pen), 0);
    chk("tst_ready", 32'(ready), 1);
    chk("tst_done", 32'(done), 0);
    chk("tst_pact", 32'(pact), 0);
    out_chk("tst_all", 4'b1111, 1);
    test_en = 1'b0;
    out_chk("tst_off", 4'b1111, 0);
    // reset in the middle of DRAIN
    req(2'd1, 1'b0);
    repeat (4) tick();
    chk("p1_done", 32'(done), 1);
    chk("p1_act", 32'(act), 1);
    req(2'd3, 1'b0);
    tick();
    rst_n = 1'b0;
    #1;
    chk("rd_pen", 32'(pen), 0);
    chk("rd_act", 32'(act), 0);
    chk("rd_pact", 32'(pact), 0);
    chk("rd_ready", 32'(ready), 1);
    repeat (2) tick();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("rd_nodone", 32'(done), 0);
      chk("rd_idle_pen", 32'(pen), 0);
    end
    // reset in the middle of SETTLE, enable already high
    req(2'd2, 1'b0);
    tick();
    chk("rs_pen_pre", 32'(pen), 4'b0100);
    rst_n = 1'b0;
    #1;
    chk("rs_pen", 32'(pen), 0);
    chk("rs_done", 32'(done), 0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("rs_nodone", 32'(done), 0);
      chk("rs_idle_pen", 32'(pen), 0);
    end
    // out-of-range requests on a 5-path instance
    p5 = 3'd5;
    v5 = 1'b1;
    tick();
    v5 = 1'b0;
    chk("err5_pulse", 32'(err5), 1);
    chk("err5_pen", 32'(pen5), 0);
    chk("err5_ready", 32'(ready5), 1);
    chk("err5_done", 32'(done5), 0);
    tick();
    chk("err5_clr", 32'(err5), 0);
    p5 = 3'd3;
    v5 = 1'b1;
    tick();
    v5 = 1'b0;
    chk("p5_pen", 32'(pen5), 5'b01000);
    chk("p5_ready", 32'(ready5), 0);
    tick();
    chk("p5_done0", 32'(done5), 0);
    tick();
    chk("p5_done", 32'(done5), 1);
    chk("p5_act", 32'(act5), 3);
    in5 = '0;
    #1 in5 = 5'b01000;
    #1 chk("out5", 32'(o5), 1);
    in5 = '0;
    p5 = 3'd7;
    v5 = 1'b1;
    tick();
    v5 = 1'b0;
    chk("err5_on", 32'(err5), 1);
    chk("err5_on_pen", 32'(pen5), 5'b01000);
    chk("err5_on_pact", 32'(pact5), 1);
    chk("err5_on_act", 32'(act5), 3);
    chk("err5_on_done", 32'(done5), 0);
    tick();
    chk("err5_on_clr", 32'(err5), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
